uart_rx_fsm: RTL and testbench
==============================

Name: uart_rx_FSM

Overview:
- UART receiver; the downstream stage of uart_tx_FSM. Consumes the serial TxD line (looped back on board or in bench) and recovers 8N1 bytes.
- Oversamples the line with a free-running tick from a BaudGen instance configured at OVERSAMPLE x baud rate.
- Delivers each byte on a parallel bus with a one-clock valid strobe, plus a framing-error strobe.
- Sits between the board RxD pin and the downstream byte consumer (FIFO / code-density histogram logic).

Parameters:
- OVERSAMPLE, 16: rx_en ticks per UART bit; power of two, >= 8.
- DATA_BITS, 8: payload bits per frame, LSB first.

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  synchronous reset, active-low (0 = reset, sampled on posedge clk)
- rx_en  input  1  oversampling tick, one clk wide, OVERSAMPLE x baud
- RxD  input  1  asynchronous serial line, idle high
- rx_data  output  DATA_BITS  last correctly framed byte
- rx_valid  output  1  one-clk pulse, rx_data updated
- framing_err  output  1  one-clk pulse, stop bit sampled low
- parity_err  output  1  one-clk pulse, parity mismatch (tied 0 without the optional feature)
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst==0 at posedge clk):
  - state=IDLE; tick_cnt=0; bit_cnt=0; shift=0.
  - rx_data=0; rx_valid=0; framing_err=0; parity_err=0; busy=0.
  - Synchroniser flops preset to 1.
  - Reset mid-frame aborts the frame with no strobe.
- RxD passes a 2-FF synchroniser (preset 1) to give rxd_s. All logic below uses rxd_s only. Input-to-rxd_s latency is 2 clk.
- tick_cnt is log2(OVERSAMPLE) bits wide, advances only on rx_en, and is cleared on every state entry. bit_cnt counts 0..DATA_BITS-1.
- IDLE: rxd_s==0 at any clk (independent of rx_en) -> START, tick_cnt=0.
- START: on rx_en, tick_cnt++. On the rx_en where tick_cnt==OVERSAMPLE/2-1 (mid start bit):
  - rxd_s==0 -> DATA, tick_cnt=0, bit_cnt=0.
  - rxd_s==1 -> IDLE. This is glitch rejection; no strobe is issued.
- DATA: on the rx_en where tick_cnt==OVERSAMPLE-1 (mid bit):
  - shift = {rxd_s, shift[DATA_BITS-1:1]} (LSB first).
  - bit_cnt==DATA_BITS-1 -> STOP (PARITY if enabled); otherwise bit_cnt++.
  - tick_cnt wraps to 0 naturally.
- STOP: on the rx_en where tick_cnt==OVERSAMPLE-1:
  - rxd_s==1 -> rx_data<=shift, rx_valid=1 for the next clk, -> IDLE.
  - rxd_s==0 -> framing_err=1 for the next clk, rx_data unchanged, -> BREAK.
- BREAK: wait for rxd_s==1, then -> IDLE. This prevents a held-low line from retriggering START.
- Strobe timing:
  - Strobes are registered and asserted on the clk edge that samples the stop bit.
  - Strobes deassert on the following edge.
  - rx_valid and framing_err are never high together.
- rx_en coinciding with a state transition: the tick is consumed by the transition and is not double-counted.
- Back-to-back frames: IDLE re-arms at mid stop bit, so a start edge arriving half a bit later is captured. This gives no byte loss at full line rate.
- rx_en held high continuously is legal; the FSM advances one tick per clk.
- Encoding: STATE is a 4-bit register exposed as an internal signal named STATE for bench probing (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, BREAK=5).

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Frame is start + DATA_BITS + even-parity bit + stop.
  - PARITY state sits between DATA and STOP and samples at mid bit into a parity flag.
  - In STOP, with rxd_s==1 and (^shift ^ parity_bit)!=0: rx_valid=1 and parity_err=1 on the same clk, and rx_data is still updated.
  - Framing error takes precedence: only framing_err fires.
- Not defined: no PARITY state; parity_err is driven constant 0; frame is 8N1.

Test Plan:
- Reset: hold rst=0 for 5 clk with RxD toggling -> all outputs 0, STATE=0; after release with RxD=1, STATE stays 0.
- Single byte:
  - Loop uart_tx_FSM TxD to RxD; BaudGen tx at 9600, rx tick at 16x (period 651 clk); send 0xA5.
  - Exactly one rx_valid pulse, rx_data=8'hA5, framing_err=0.
  - Pulse occurs ~9.5 bit periods after the start edge.
- Glitch: drive RxD low for 3 rx_en ticks, then high -> STATE returns to IDLE, no strobe.
- Framing error / break:
  - Drive 0x3C with stop bit forced 0, then hold RxD low for 20 bits -> one framing_err pulse, rx_data keeps its previous value, STATE=BREAK until RxD rises, no further strobes.
- Back-to-back: 10 $random bytes with no idle gap -> 10 rx_valid pulses, data matches the sent sequence in order.
- Parity (UART_RX_PARITY_EN):
  - 0x07 with correct parity bit 1 -> rx_valid, parity_err=0.
  - Same frame with parity bit 0 -> rx_valid=1 and parity_err=1 on the same clk.

Source files
------------

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: oversampled UART receiver, start + DATA_BITS (LSB first) + stop.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data and stop bits.
module uart_rx_fsm #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_en,
   input  logic                 RxD,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 framing_err,
   output logic                 parity_err,
   output logic                 busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      START  = 4'd1,
      DATA   = 4'd2,
      PARITY = 4'd3,
      STOP   = 4'd4,
      BREAK  = 4'd5
   } state_t;

   state_t               state_q, state_d;
   logic [3:0]           STATE;
   logic                 rxd_meta_q, rxd_meta_d;
   logic                 rxd_s_q, rxd_s_d;
   logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
   logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 framing_err_q, framing_err_d;
`ifdef UART_RX_PARITY_EN
   logic                 par_bit_q, par_bit_d;
   logic                 parity_err_q, parity_err_d;
`endif

   always_comb begin
      rxd_meta_d    = RxD;
      rxd_s_d       = rxd_meta_q;
      state_d       = state_q;
      tick_cnt_d    = tick_cnt_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = 1'b0;
      framing_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_d     = par_bit_q;
      parity_err_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (!rxd_s_q) begin
               state_d    = START;
               tick_cnt_d = '0;
            end
         end
         // Half a bit into the start bit: a line that is high again was a glitch.
         START: begin
            if (rx_en) begin
               if (tick_cnt_q == TICK_MID) begin
                  tick_cnt_d = '0;
                  if (!rxd_s_q) begin
                     state_d   = DATA;
                     bit_cnt_d = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
         DATA: begin
            if (rx_en) begin
               tick_cnt_d = tick_cnt_q + 1'b1;
               if (tick_cnt_q == TICK_LAST) begin
                  shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
                  if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_d = PARITY;
`else
                     state_d = STOP;
`endif
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (rx_en) begin
               tick_cnt_d = tick_cnt_q + 1'b1;
               if (tick_cnt_q == TICK_LAST) begin
                  par_bit_d = rxd_s_q;
                  state_d   = STOP;
               end
            end
         end
`endif
         // Returning to IDLE at mid stop bit leaves half a bit to catch the next start edge.
         STOP: begin
            if (rx_en) begin
               tick_cnt_d = tick_cnt_q + 1'b1;
               if (tick_cnt_q == TICK_LAST) begin
                  tick_cnt_d = '0;
                  if (rxd_s_q) begin
                     rx_data_d  = shift_q;
                     rx_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                     parity_err_d = (^shift_q) ^ par_bit_q;
`endif
                     state_d = IDLE;
                  end else begin
                     framing_err_d = 1'b1;
                     state_d       = BREAK;
                  end
               end
            end
         end
         BREAK: begin
            if (rxd_s_q) begin
               state_d    = IDLE;
               tick_cnt_d = '0;
            end
         end
         default: begin
            state_d    = IDLE;
            tick_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rxd_meta_q    <= 1'b1;
         rxd_s_q       <= 1'b1;
         state_q       <= IDLE;
         tick_cnt_q    <= '0;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         framing_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit_q     <= 1'b0;
         parity_err_q  <= 1'b0;
`endif
      end else begin
         rxd_meta_q    <= rxd_meta_d;
         rxd_s_q       <= rxd_s_d;
         state_q       <= state_d;
         tick_cnt_q    <= tick_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         framing_err_q <= framing_err_d;
`ifdef UART_RX_PARITY_EN
         par_bit_q     <= par_bit_d;
         parity_err_q  <= parity_err_d;
`endif
      end
   end

   assign STATE       = state_q;
   assign busy        = (STATE != 4'd0);
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign framing_err = framing_err_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err  = parity_err_q;
`else
   assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: bench-side serial transmitter drives RxD with randomized frames;
// a frame-level expectation queue predicts every strobe, its data and its timing.
`timescale 1ns/1ps
module tb_uart_rx_fsm;

   localparam int OVERSAMPLE = 16;
   localparam int DATA_BITS  = 8;
`ifdef UART_RX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   // rx_en ticks from leaving IDLE until the stop bit is sampled
   localparam int LAT_TICKS = OVERSAMPLE / 2 + OVERSAMPLE * (DATA_BITS + PAR_BITS + 1);

   typedef struct {
      logic       ferr;
      logic       perr;
      logic [7:0] data;
      int         start_cyc;
      int         div;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 rx_en = 1'b0;
   logic                 RxD = 1'b1;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid, framing_err, parity_err, busy;

   exp_t       exp_q[$];
   exp_t       mon_ev;
   int         mon_lat;
   logic [7:0] last_good = 8'h00;
   logic       mon_en = 1'b0;
   int         n_checks = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         div = 4;
   int         div_cnt = 0;

   uart_rx_fsm #(.OVERSAMPLE(OVERSAMPLE), .DATA_BITS(DATA_BITS)) dut (
      .clk(clk), .rst(rst), .rx_en(rx_en), .RxD(RxD),
      .rx_data(rx_data), .rx_valid(rx_valid), .framing_err(framing_err),
      .parity_err(parity_err), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial forever begin
      @(negedge clk);
      if (div_cnt >= div - 1) begin
         rx_en = 1'b1;
         div_cnt = 0;
      end else begin
         rx_en = 1'b0;
         div_cnt++;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Caller is positioned at a negedge; returns positioned at a negedge.
   task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic bad_par);
      exp_t ev;
      logic bits[$];
      int   bclk;
      bclk = OVERSAMPLE * div;
      bits.push_back(1'b0);
      for (int i = 0; i < DATA_BITS; i++) bits.push_back(data[i]);
`ifdef UART_RX_PARITY_EN
      bits.push_back((^data) ^ bad_par);
`endif
      bits.push_back(stop_bit);
      ev.ferr      = ~stop_bit;
      ev.perr      = (PAR_BITS != 0) && stop_bit && bad_par;
      ev.data      = stop_bit ? data : last_good;
      ev.start_cyc = cyc;
      ev.div       = div;
      if (stop_bit) last_good = data;
      exp_q.push_back(ev);
      foreach (bits[k]) begin
         RxD = bits[k];
         repeat (bclk) @(negedge clk);
      end
   endtask

   task automatic drain(input string tag, input int max_cyc);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, exp_q.size(), 32'd0);
   endtask

   initial forever begin
      @(negedge clk);
      if (mon_en && (rx_valid === 1'b1 || framing_err === 1'b1 || parity_err === 1'b1)) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_strobe", {29'd0, rx_valid, framing_err, parity_err}, 32'd0);
         end else begin
            mon_ev  = exp_q.pop_front();
            mon_lat = cyc - mon_ev.start_cyc;
            check_eq("strobe_kind", {30'd0, rx_valid, framing_err}, mon_ev.ferr ? 32'd1 : 32'd2);
            check_eq("rx_data", rx_data, mon_ev.data);
            check_eq("parity_err", parity_err, mon_ev.perr);
            check_eq($sformatf("latency_window(%0d clk)", mon_lat),
                     (mon_lat >= LAT_TICKS * mon_ev.div - mon_ev.div) &&
                     (mon_lat <= LAT_TICKS * mon_ev.div + 5), 32'd1);
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      // reset with a toggling line
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         RxD = i[0];
      end
      check_eq("rst_rx_data", rx_data, 32'd0);
      check_eq("rst_rx_valid", rx_valid, 32'd0);
      check_eq("rst_framing_err", framing_err, 32'd0);
      check_eq("rst_parity_err", parity_err, 32'd0);
      check_eq("rst_busy", busy, 32'd0);
      check_eq("rst_state", dut.STATE, 32'd0);
      RxD = 1'b1;
      rst = 1'b1;
      repeat (20) @(negedge clk);
      check_eq("post_rst_state", dut.STATE, 32'd0);
      mon_en = 1'b1;

      // single byte
      send_frame(8'hA5, 1'b1, 1'b0);
      drain("single_drain", 2000);
      repeat (OVERSAMPLE * div) @(negedge clk);
      check_eq("single_idle", dut.STATE, 32'd0);

      // start-bit glitch
      RxD = 1'b0;
      repeat (3 * div) @(negedge clk);
      check_eq("glitch_in_start", dut.STATE, 32'd1);
      RxD = 1'b1;
      repeat (OVERSAMPLE * div) @(negedge clk);
      check_eq("glitch_back_idle", dut.STATE, 32'd0);
      check_eq("glitch_busy", busy, 32'd0);

      // back-to-back random bytes, no idle gap
      for (int i = 0; i < 10; i++) begin
         b = 8'($urandom);
         send_frame(b, 1'b1, 1'b0);
      end
      RxD = 1'b1;
      drain("b2b_drain", 2000);

      // framing error followed by a held-low line
      send_frame(8'h3C, 1'b0, 1'b0);
      repeat (2 * OVERSAMPLE * div) @(negedge clk);
      check_eq("break_state", dut.STATE, 32'd5);
      check_eq("break_rx_data_kept", rx_data, last_good);
      repeat (18 * OVERSAMPLE * div) @(negedge clk);
      check_eq("break_state_held", dut.STATE, 32'd5);
      drain("break_drain", 10);
      RxD = 1'b1;
      repeat (5) @(negedge clk);
      check_eq("break_exit_idle", dut.STATE, 32'd0);

      // reset mid-frame aborts silently
      RxD = 1'b0;
      repeat (3 * OVERSAMPLE * div) @(negedge clk);
      check_eq("abort_busy_before", busy, 32'd1);
      rst = 1'b0;
      RxD = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("abort_state", dut.STATE, 32'd0);
      check_eq("abort_busy", busy, 32'd0);
      check_eq("abort_rx_data", rx_data, 32'd0);
      last_good = 8'h00;
      rst = 1'b1;
      repeat (12 * OVERSAMPLE * div) @(negedge clk);
      check_eq("abort_stays_idle", dut.STATE, 32'd0);

      // rx_en held high continuously
      div = 1;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom);
         send_frame(b, 1'b1, 1'b0);
      end
      RxD = 1'b1;
      drain("cont_drain", 500);
      div = 4;
      repeat (8) @(negedge clk);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b0);
      drain("par_good_drain", 2000);
      send_frame(8'h07, 1'b1, 1'b1);
      drain("par_bad_drain", 2000);
      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom);
         send_frame(b, 1'b1, 1'($urandom_range(0, 1)));
      end
      RxD = 1'b1;
      drain("par_rand_drain", 2000);
`endif

      repeat (2 * OVERSAMPLE * div) @(negedge clk);
      check_eq("final_queue_empty", exp_q.size(), 32'd0);
      check_eq("final_idle", dut.STATE, 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
